// File: rtl/scoreboard_pkg.sv
// scoreboard_pkg: shared sizing constants for the register scoreboard
package scoreboard_pkg;
  localparam int NREG = 32;
  localparam int SB_CNT_W = 2;
  localparam int SB_MAX = 3;
  localparam int INFLIGHT_W = 6;
endpackage

// File: rtl/scoreboard_sb_counter.sv
// sb_counter: saturating up/down outstanding-write counter with underflow flag
module sb_counter
  import scoreboard_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                inc,
  input  logic                dec,
  output logic [SB_CNT_W-1:0] cnt,
  output logic                err
);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (inc && !dec && cnt != SB_CNT_W'(SB_MAX)) cnt <= cnt + 1'b1;
    else if (dec && !inc && cnt != '0) cnt <= cnt - 1'b1;
  assign err = dec && cnt == '0;
endmodule

// File: rtl/scoreboard.sv
// scoreboard: tracks outstanding long-op register writes and raises ID-stage stalls
module scoreboard
  import scoreboard_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  input  logic                  issue_wr,
  input  logic                  issue_long,
  input  logic [4:0]            issue_rd,
  input  logic [4:0]            rs1_id,
  input  logic [4:0]            rs2_id,
  input  logic                  rs1_use,
  input  logic                  rs2_use,
  input  logic                  wb_valid,
  input  logic [4:0]            wb_rd,
  output logic                  stall_ra,
  output logic                  stall_rb,
  output logic                  stall,
  output logic [NREG-1:0]       pending,
  output logic [INFLIGHT_W-1:0] inflight,
  output logic                  sb_err
);
  logic [NREG-1:0][SB_CNT_W-1:0] cnt;
  logic [NREG-1:1] inc, dec, err;
  logic track, sat;
  assign cnt[0] = '0;
  assign pending[0] = 1'b0;
  assign track = issue_valid && !stall && issue_wr && issue_long && issue_rd != '0;
  for (genvar g = 1; g < NREG; g++) begin : g_cnt
    assign inc[g] = track && issue_rd == 5'(g);
    assign dec[g] = wb_valid && wb_rd == 5'(g);
    assign pending[g] = cnt[g] != '0;
    sb_counter u_cnt (
      .clk(clk),
      .rst(rst),
      .inc(inc[g]),
      .dec(dec[g]),
      .cnt(cnt[g]),
      .err(err[g])
    );
  end
  assign stall_ra = rs1_use && rs1_id != '0 && cnt[rs1_id] != '0 &&
                    !(wb_valid && wb_rd == rs1_id && cnt[rs1_id] == SB_CNT_W'(1));
  assign stall_rb = rs2_use && rs2_id != '0 && cnt[rs2_id] != '0 &&
                    !(wb_valid && wb_rd == rs2_id && cnt[rs2_id] == SB_CNT_W'(1));
  assign sat = issue_wr && issue_long && cnt[issue_rd] == SB_CNT_W'(SB_MAX) &&
               !(wb_valid && wb_rd == issue_rd);
  assign stall = issue_valid && (stall_ra || stall_rb || sat);
  always_comb begin
    inflight = '0;
    for (int i = 1; i < NREG; i++) inflight = inflight + INFLIGHT_W'(cnt[i]);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) sb_err <= 1'b0;
    else if (|err) sb_err <= 1'b1;
endmodule

// File: tb/tb_scoreboard.sv
// tb_scoreboard: directed and random checks of scoreboard against a counting reference model
module tb_scoreboard;
  import scoreboard_pkg::*;
  logic clk = 1'b0, rst = 1'b1;
  logic issue_valid = 0, issue_wr = 0, issue_long = 0, rs1_use = 0, rs2_use = 0, wb_valid = 0;
  logic [4:0] issue_rd = 0, rs1_id = 0, rs2_id = 0, wb_rd = 0;
  logic stall_ra, stall_rb, stall, sb_err;
  logic [NREG-1:0] pending;
  logic [INFLIGHT_W-1:0] inflight;
  int checks = 0, errors = 0;
  int cnt_m[NREG];
  bit err_m;
  scoreboard dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_wr(issue_wr), .issue_long(issue_long), .issue_rd(issue_rd),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_use(rs1_use), .rs2_use(rs2_use),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
    .stall_ra(stall_ra), .stall_rb(stall_rb), .stall(stall),
    .pending(pending), .inflight(inflight), .sb_err(sb_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic drive(input bit iv, input bit wr, input bit lg, input int rd,
                       input bit u1, input int r1, input bit u2, input int r2,
                       input bit wv, input int wrd);
    issue_valid = iv; issue_wr = wr; issue_long = lg; issue_rd = 5'(rd);
    rs1_use = u1; rs1_id = 5'(r1); rs2_use = u2; rs2_id = 5'(r2);
    wb_valid = wv; wb_rd = 5'(wrd);
  endtask
  function automatic int wb_hit(input int r);
    return (wb_valid && r != 0 && int'(wb_rd) == r) ? 1 : 0;
  endfunction
  function automatic logic [31:0] pend_m();
    logic [31:0] p = '0;
    for (int i = 1; i < NREG; i++) p[i] = cnt_m[i] > 0;
    return p;
  endfunction
  function automatic int sum_m();
    int s = 0;
    for (int i = 1; i < NREG; i++) s += cnt_m[i];
    return s % 64;
  endfunction
  task automatic check_state(input string tag);
    chk({tag, "_pending"}, pending, pend_m());
    chk({tag, "_inflight"}, 32'(inflight), 32'(sum_m()));
    chk({tag, "_sb_err"}, 32'(sb_err), 32'(err_m));
  endtask
  task automatic step(input string tag);
    bit s1, s2, sat, st, trk;
    int nxt[NREG];
    #1;
    s1 = rs1_use && rs1_id != 0 && cnt_m[rs1_id] - wb_hit(int'(rs1_id)) > 0;
    s2 = rs2_use && rs2_id != 0 && cnt_m[rs2_id] - wb_hit(int'(rs2_id)) > 0;
    sat = issue_wr && issue_long && issue_rd != 0 && cnt_m[issue_rd] - wb_hit(int'(issue_rd)) >= SB_MAX;
    st = issue_valid && (s1 || s2 || sat);
    trk = issue_valid && !st && issue_wr && issue_long && issue_rd != 0;
    chk({tag, "_stall_ra"}, 32'(stall_ra), 32'(s1));
    chk({tag, "_stall_rb"}, 32'(stall_rb), 32'(s2));
    chk({tag, "_stall"}, 32'(stall), 32'(st));
    check_state(tag);
    nxt = cnt_m;
    if (wb_valid && wb_rd != 0 && cnt_m[wb_rd] == 0) err_m = 1;
    if (trk) nxt[issue_rd] += 1;
    if (wb_valid && wb_rd != 0) nxt[wb_rd] -= 1;
    for (int i = 0; i < NREG; i++) if (nxt[i] < 0) nxt[i] = 0;
    @(posedge clk);
    cnt_m = nxt;
    @(negedge clk);
  endtask
  task automatic model_reset();
    for (int i = 0; i < NREG; i++) cnt_m[i] = 0;
    err_m = 0;
  endtask
  initial begin
    model_reset();
    #2;
    chk("rst_pending", pending, 0);
    chk("rst_inflight", 32'(inflight), 0);
    chk("rst_sb_err", 32'(sb_err), 0);
    chk("rst_stall", 32'(stall), 0);
    @(negedge clk);
    rst = 0;
    drive(1, 1, 1, 5, 0, 0, 0, 0, 0, 0); step("r38_issue");
    drive(0, 0, 0, 0, 1, 5, 0, 0, 0, 0); step("r38_read");
    chk("r38_stall_ra", 32'(stall_ra), 1);
    chk("r38_pending5", 32'(pending[5]), 1);
    chk("r38_inflight", 32'(inflight), 1);
    drive(1, 0, 0, 0, 1, 5, 0, 0, 1, 5); #1;
    chk("r39_wb_bypass_stall", 32'(stall), 0);
    step("r39_wb");
    chk("r39_pending5", 32'(pending[5]), 0);
    chk("r39_inflight", 32'(inflight), 0);
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 1, 7, 0, 0, 0, 0, 0, 0); step("r40_fill");
    end
    chk("r40_inflight3", 32'(inflight), 3);
    drive(1, 1, 1, 7, 0, 0, 0, 0, 0, 0); #1;
    chk("r40_sat_stall", 32'(stall), 1);
    step("r40_sat");
    chk("r40_still3", 32'(inflight), 3);
    drive(1, 1, 1, 7, 0, 0, 0, 0, 1, 7); #1;
    chk("r40_wb_accept", 32'(stall), 0);
    step("r40_swap");
    chk("r40_swap_cnt", 32'(inflight), 3);
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 7); step("r40_drain");
    end
    drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0); step("r41_x0");
    drive(1, 1, 0, 9, 1, 0, 0, 0, 0, 0); step("r41_short");
    drive(1, 0, 0, 0, 1, 9, 1, 0, 0, 0); step("r41_read");
    chk("r41_stall", 32'(stall), 0);
    chk("r41_pending", pending, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 12); step("r42_underflow");
    chk("r42_err", 32'(sb_err), 1);
    chk("r42_cnt12", 32'(pending[12]), 0);
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step("r42_hold");
    end
    chk("r42_sticky", 32'(sb_err), 1);
    drive(1, 1, 1, 3, 0, 0, 0, 0, 0, 0); step("r43_a");
    drive(1, 1, 1, 4, 0, 0, 0, 0, 0, 0); step("r43_b");
    drive(0, 0, 0, 0, 1, 3, 1, 4, 0, 0);
    chk("r43_pre_inflight", 32'(inflight), 2);
    #2 rst = 1;
    #1;
    chk("r43_pending", pending, 0);
    chk("r43_inflight", 32'(inflight), 0);
    chk("r43_sb_err", 32'(sb_err), 0);
    chk("r43_stall_ra", 32'(stall_ra), 0);
    chk("r43_stall_rb", 32'(stall_rb), 0);
    model_reset();
    @(negedge clk);
    rst = 0;
    for (int k = 0; k < 400; k++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
            $urandom_range(0, 1), $urandom_range(0, 7),
            $urandom_range(0, 2) == 0, $urandom_range(0, 7));
      step("rnd");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
